gear_box_ctrl: RTL and testbench

Parametrised gearbox controller for the player car, replacing the fixed 2-bit up-only shifter. It accepts single-cycle upshift/downshift key pulses from the keyboard edge detectors and holds the current gear (0 = neutral, 1..NUM_GEARS). It enforces a post-shift lockout and grades each upshift against an RPM window. It sits between the keyboard front-end and the speed/RPM model.

---
 rtl/gear_pkg.sv | 26 ++
 rtl/gear_box_ctrl_if.sv | 34 +++
 rtl/shift_lock_timer.sv | 36 +++
 rtl/gear_box_ctrl.sv | 142 ++++++++++++++
 tb/tb_gear_box_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gear_pkg.sv
// rtl/gear_pkg.sv - shared types, default constants and width helper for the gearbox controller
//
// Purpose : FSM state type, default gearbox constants and a helper that
//           returns the narrowest gear register able to hold NUM_GEARS.
// Ports   : none (package).
package gear_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int DEF_NUM_GEARS   = 5;
   localparam int DEF_LOCK_CYCLES = 8;
   localparam int DEF_PERFECT_LO  = 6000;
   localparam int DEF_PERFECT_HI  = 7000;

   // Smallest width w with 2**w > num_gears.
   function automatic int min_gear_w(input int num_gears);
      int w;
      w = 1;
      while ((1 << w) <= num_gears) w++;
      return w;
   endfunction

endpackage

// File: rtl/gear_box_ctrl_if.sv
// rtl/gear_box_ctrl_if.sv - shift request / gear status bundle between keyboard front-end and gearbox
//
// Purpose : groups the race-restart, shift requests, RPM and the gearbox
//           status outputs.
// Ports   : reset_status, up_posedge, down_posedge, rpm   (front-end -> gearbox)
//           gear, busy, shift_done, perfect_shift,
//           shift_reject                                 (gearbox -> model)
// Modports: master = front-end / model side, slave = gearbox.
interface gear_box_ctrl_if #(
   parameter int GEAR_W = 4,
   parameter int RPM_W  = 14
) ();

   logic              reset_status;
   logic              up_posedge;
   logic              down_posedge;
   logic [RPM_W-1:0]  rpm;
   logic [GEAR_W-1:0] gear;
   logic              busy;
   logic              shift_done;
   logic              perfect_shift;
   logic              shift_reject;

   modport master (
      output reset_status, up_posedge, down_posedge, rpm,
      input  gear, busy, shift_done, perfect_shift, shift_reject
   );

   modport slave (
      input  reset_status, up_posedge, down_posedge, rpm,
      output gear, busy, shift_done, perfect_shift, shift_reject
   );

endinterface

// File: rtl/shift_lock_timer.sv
// rtl/shift_lock_timer.sv - loadable down-counter timing the post-shift lockout
//
// Purpose : counts down from a loaded value to zero, one step per cycle.
// Ports   : clk    in  system clock
//           rst    in  asynchronous active-low reset
//           load   in  load value into the counter (wins over counting)
//           value  in  count to load
//           active out counter is non-zero
module shift_lock_timer
   import gear_pkg::*;
#(
   parameter  int LOCK_CYCLES = DEF_LOCK_CYCLES,
   localparam int CNT_W       = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             active
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign active = (count_q != '0);

endmodule

// File: rtl/gear_box_ctrl.sv
// rtl/gear_box_ctrl.sv - parametrised gearbox controller with shift lockout and perfect-upshift grading
//
// Purpose : holds the current gear (0 = neutral .. NUM_GEARS), accepts one
//           shift request per cycle in IDLE, locks out further shifts for
//           LOCK_CYCLES cycles after each accepted shift and flags upshifts
//           taken inside the [PERFECT_LO, PERFECT_HI] RPM window.
// Ports   : clk  in  system clock
//           rst  in  asynchronous active-low reset
//           bus  slave modport of gear_box_ctrl_if (requests in, status out)
module gear_box_ctrl
   import gear_pkg::*;
#(
   parameter int NUM_GEARS   = DEF_NUM_GEARS,
   parameter int GEAR_W      = 4,
   parameter int RPM_W       = 14,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int PERFECT_LO  = DEF_PERFECT_LO,
   parameter int PERFECT_HI  = DEF_PERFECT_HI
) (
   input logic            clk,
   input logic            rst,
   gear_box_ctrl_if.slave bus
);

   localparam int                CNT_W     = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
   localparam logic [GEAR_W-1:0] TOP_GEAR  = GEAR_W'(NUM_GEARS);
   localparam logic [RPM_W-1:0]  RPM_LO    = RPM_W'(PERFECT_LO);
   localparam logic [RPM_W-1:0]  RPM_HI    = RPM_W'(PERFECT_HI);
   // Loading LOCK_CYCLES-1 keeps busy high for exactly LOCK_CYCLES cycles,
   // because the FSM leaves LOCK one cycle after the counter reaches zero.
   localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'((LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0);

   if (NUM_GEARS < 1 || NUM_GEARS > 15) begin : g_bad_num_gears
      $error("gear_box_ctrl: NUM_GEARS must be 1..15");
   end
   if (GEAR_W < min_gear_w(NUM_GEARS)) begin : g_bad_gear_w
      $error("gear_box_ctrl: GEAR_W too narrow for NUM_GEARS");
   end
   if (LOCK_CYCLES < 0) begin : g_bad_lock
      $error("gear_box_ctrl: LOCK_CYCLES must be >= 0");
   end
   if (PERFECT_LO > PERFECT_HI || PERFECT_HI >= (1 << RPM_W)) begin : g_bad_window
      $error("gear_box_ctrl: RPM window invalid for RPM_W");
   end

   state_t            state_q, state_d;
   logic [GEAR_W-1:0] gear_q, gear_d;
   logic              done_q, done_d;
   logic              perf_q, perf_d;
   logic              rej_q, rej_d;
   logic              lock_load;
   logic [CNT_W-1:0]  lock_value;
   logic              lock_active;
   logic              in_window;
   logic              single_req;
   logic              accept;

   shift_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (lock_load),
      .value (lock_value),
      .active(lock_active)
   );

   assign in_window  = (bus.rpm >= RPM_LO) && (bus.rpm <= RPM_HI);
   // Both keys in the same cycle is treated as no request at all.
   assign single_req = bus.up_posedge ^ bus.down_posedge;

   always_comb begin
      state_d    = state_q;
      gear_d     = gear_q;
      done_d     = 1'b0;
      perf_d     = 1'b0;
      rej_d      = 1'b0;
      lock_load  = 1'b0;
      lock_value = '0;
      accept     = 1'b0;

      if (bus.reset_status) begin
         // Race restart: clear everything, including a running lockout.
         state_d   = IDLE;
         gear_d    = '0;
         lock_load = 1'b1;
      end else begin
         if (single_req) begin
            if (state_q == LOCK) begin
               rej_d = 1'b1;
            end else if (bus.up_posedge) begin
               if (gear_q < TOP_GEAR) begin
                  gear_d = gear_q + 1'b1;
                  accept = 1'b1;
                  perf_d = in_window;
               end else begin
                  rej_d = 1'b1;
               end
            end else begin
               if (gear_q != '0) begin
                  gear_d = gear_q - 1'b1;
                  accept = 1'b1;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end

         if (state_q == LOCK && !lock_active) begin
            state_d = IDLE;
         end

         done_d = accept;
         if (accept && LOCK_CYCLES > 0) begin
            state_d    = LOCK;
            lock_load  = 1'b1;
            lock_value = LOCK_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gear_q  <= '0;
         done_q  <= 1'b0;
         perf_q  <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gear_q  <= gear_d;
         done_q  <= done_d;
         perf_q  <= perf_d;
         rej_q   <= rej_d;
      end
   end

   assign bus.gear          = gear_q;
   assign bus.busy          = (state_q == LOCK);
   assign bus.shift_done    = done_q;
   assign bus.perfect_shift = perf_q;
   assign bus.shift_reject  = rej_q;

endmodule

// File: tb/tb_gear_box_ctrl.sv
// tb/tb_gear_box_ctrl.sv - self-checking bench for gear_box_ctrl (LOCK_CYCLES=8 and LOCK_CYCLES=0 instances)
module tb_gear_box_ctrl;

   localparam int GW = 4;
   localparam int RW = 14;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   gear_box_ctrl_if #(.GEAR_W(GW), .RPM_W(RW)) bus8 ();
   gear_box_ctrl_if #(.GEAR_W(GW), .RPM_W(RW)) bus0 ();

   gear_box_ctrl #(
      .NUM_GEARS(5), .GEAR_W(GW), .RPM_W(RW), .LOCK_CYCLES(8),
      .PERFECT_LO(6000), .PERFECT_HI(7000)
   ) dut8 (
      .clk(clk),
      .rst(rst),
      .bus(bus8.slave)
   );

   gear_box_ctrl #(
      .NUM_GEARS(5), .GEAR_W(GW), .RPM_W(RW), .LOCK_CYCLES(0),
      .PERFECT_LO(6000), .PERFECT_HI(7000)
   ) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0.slave)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Reference state: gear and remaining busy cycles for each instance.
   int mg8 = 0, mr8 = 0, mg0 = 0, mr0 = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_v, got_v;

   // Behavioural reference: rem counts busy cycles still to be shown.
   task automatic model(input int lock, inout int g, inout int rem,
                        input bit up, input bit dn, input bit rs, input int rpm,
                        output logic [7:0] e);
      bit acc, rej, perf;
      acc = 0; rej = 0; perf = 0;
      if (rs) begin
         g = 0; rem = 0;
      end else begin
         if (up != dn) begin
            if (rem > 0) rej = 1;
            else if (up && g < 5) begin g++; acc = 1; perf = (rpm >= 6000 && rpm <= 7000); end
            else if (dn && g > 0) begin g--; acc = 1; end
            else rej = 1;
         end
         if (acc) rem = lock;
         else if (rem > 0) rem--;
      end
      e = {4'(g), (rem > 0), acc, perf, rej};
   endtask

   function automatic logic [15:0] sample();
      return {bus8.gear, bus8.busy, bus8.shift_done, bus8.perfect_shift, bus8.shift_reject,
              bus0.gear, bus0.busy, bus0.shift_done, bus0.perfect_shift, bus0.shift_reject};
   endfunction

   task automatic set_inputs(input bit up, input bit dn, input int rpm, input bit rs);
      bus8.up_posedge = up; bus8.down_posedge = dn; bus8.rpm = RW'(rpm); bus8.reset_status = rs;
      bus0.up_posedge = up; bus0.down_posedge = dn; bus0.rpm = RW'(rpm); bus0.reset_status = rs;
   endtask

   // One clock of stimulus; expected result for both instances goes to the scoreboard.
   task automatic cyc(input bit up, input bit dn, input int rpm, input bit rs);
      logic [7:0] e8, e0;
      set_inputs(up, dn, rpm, rs);
      model(8, mg8, mr8, up, dn, rs, rpm, e8);
      model(0, mg0, mr0, up, dn, rs, rpm, e0);
      sb.push_back({e8, e0});
      @(posedge clk);
      #1;
      set_inputs(0, 0, 0, 0);
   endtask

   // Restart the race and climb to gear n, with idle gaps longer than the lockout.
   task automatic go_gear(input int n);
      cyc(0, 0, 0, 1);
      for (int k = 0; k < n; k++) begin
         cyc(1, 0, 5000, 0);
         repeat (9) cyc(0, 0, 0, 0);
      end
      sb.delete();
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (sample() !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_state: got %h required 0000", sample());
      end
      rst = 1'b1;
      mg8 = 0; mr8 = 0; mg0 = 0; mr0 = 0;
      cyc(0, 0, 0, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL reset_idle: got %h required %h", got_v, exp_v);
      end
   endtask

   task automatic test_upshift_limit;
      go_gear(0);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 5000, 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL upshift_sb %0d: got %h required %h", i, got_v, exp_v);
         end
         vectors++;
         if (i < 5) begin
            if (bus8.gear !== 4'(i + 1) || bus8.shift_done !== 1'b1) begin
               miscompares++;
               $display("FAIL upshift_gear %0d: got gear %0d done %b required gear %0d done 1",
                        i, bus8.gear, bus8.shift_done, i + 1);
            end
         end else if (bus8.gear !== 4'd5 || bus8.shift_reject !== 1'b1 || bus8.shift_done !== 1'b0) begin
            miscompares++;
            $display("FAIL upshift_top: got gear %0d rej %b done %b required gear 5 rej 1 done 0",
                     bus8.gear, bus8.shift_reject, bus8.shift_done);
         end
         repeat (19) begin
            cyc(0, 0, 0, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL upshift_gap %0d: got %h required %h", i, got_v, exp_v);
            end
         end
      end
   endtask

   task automatic test_lockout;
      int bcnt, guard;
      go_gear(3);
      cyc(1, 0, 5000, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL lock_accept_sb: got %h required %h", got_v, exp_v);
      end
      vectors++;
      if (bus8.gear !== 4'd4 || bus8.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_accept: got gear %0d busy %b required gear 4 busy 1", bus8.gear, bus8.busy);
      end
      bcnt = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(i == 2, 0, 5000, 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL lock_hold_sb %0d: got %h required %h", i, got_v, exp_v);
         end
         if (bus8.busy) bcnt++;
      end
      vectors++;
      if (bus8.shift_reject !== 1'b1 || bus8.gear !== 4'd4) begin
         miscompares++;
         $display("FAIL lock_reject: got rej %b gear %0d required rej 1 gear 4", bus8.shift_reject, bus8.gear);
      end
      guard = 0;
      while (bus8.busy && guard < 20) begin
         cyc(0, 0, 0, 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL lock_wait_sb %0d: got %h required %h", guard, got_v, exp_v);
         end
         if (bus8.busy) bcnt++;
         guard++;
      end
      vectors++;
      if (bcnt !== 8) begin
         miscompares++;
         $display("FAIL lock_busy_len: got %0d cycles required 8", bcnt);
      end
      cyc(1, 0, 5000, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL lock_after_sb: got %h required %h", got_v, exp_v);
      end
      vectors++;
      if (bus8.gear !== 4'd5 || bus8.shift_done !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_after: got gear %0d done %b required gear 5 done 1", bus8.gear, bus8.shift_done);
      end
   endtask

   task automatic test_perfect_window;
      int rpms[4] = '{5999, 6000, 7000, 7001};
      bit  pexp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int  pcnt, dcnt;
      pcnt = 0; dcnt = 0;
      go_gear(0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, rpms[i], 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL perfect_sb rpm %0d: got %h required %h", rpms[i], got_v, exp_v);
         end
         vectors++;
         if (bus8.shift_done !== 1'b1 || bus8.perfect_shift !== pexp[i]) begin
            miscompares++;
            $display("FAIL perfect rpm %0d: got done %b perfect %b required done 1 perfect %b",
                     rpms[i], bus8.shift_done, bus8.perfect_shift, pexp[i]);
         end
         pcnt += int'(bus8.perfect_shift); dcnt += int'(bus8.shift_done);
         repeat (9) begin
            cyc(0, 0, 6500, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL perfect_gap rpm %0d: got %h required %h", rpms[i], got_v, exp_v);
            end
            pcnt += int'(bus8.perfect_shift); dcnt += int'(bus8.shift_done);
         end
      end
      vectors++;
      if (pcnt !== 2 || dcnt !== 4) begin
         miscompares++;
         $display("FAIL perfect_count: got perfect %0d done %0d required perfect 2 done 4", pcnt, dcnt);
      end
   endtask

   task automatic test_simultaneous_down;
      go_gear(2);
      cyc(1, 1, 6500, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL both_keys_sb: got %h required %h", got_v, exp_v);
      end
      vectors++;
      if (got_v[15:8] !== 8'h20) begin
         miscompares++;
         $display("FAIL both_keys: got %h required 20 (gear 2, no pulses)", got_v[15:8]);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 6500, 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL down_sb %0d: got %h required %h", k, got_v, exp_v);
         end
         vectors++;
         if (k < 2) begin
            if (bus8.gear !== 4'(1 - k) || bus8.shift_done !== 1'b1 || bus8.perfect_shift !== 1'b0) begin
               miscompares++;
               $display("FAIL down %0d: got gear %0d done %b perfect %b required gear %0d done 1 perfect 0",
                        k, bus8.gear, bus8.shift_done, bus8.perfect_shift, 1 - k);
            end
         end else if (bus8.gear !== 4'd0 || bus8.shift_reject !== 1'b1) begin
            miscompares++;
            $display("FAIL down_floor: got gear %0d rej %b required gear 0 rej 1", bus8.gear, bus8.shift_reject);
         end
         repeat (9) begin
            cyc(0, 0, 0, 0);
            exp_v = sb.pop_front(); got_v = sample(); vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL down_gap %0d: got %h required %h", k, got_v, exp_v);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      go_gear(3);
      cyc(1, 0, 5000, 0);
      cyc(0, 0, 0, 0);
      sb.delete();
      vectors++;
      if (bus8.gear !== 4'd4 || bus8.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL async_setup: got gear %0d busy %b required gear 4 busy 1", bus8.gear, bus8.busy);
      end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (bus8.gear !== 4'd0 || bus8.busy !== 1'b0 || bus0.gear !== 4'd0) begin
         miscompares++;
         $display("FAIL async_reset: got gear %0d busy %b gear0 %0d required 0 0 0",
                  bus8.gear, bus8.busy, bus0.gear);
      end
      mg8 = 0; mr8 = 0; mg0 = 0; mr0 = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1, 0, 5000, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL async_recover: got %h required %h", got_v, exp_v);
      end
   endtask

   task automatic test_reset_status;
      go_gear(2);
      cyc(1, 0, 6500, 1);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL restart_sb: got %h required %h", got_v, exp_v);
      end
      vectors++;
      if (bus8.gear !== 4'd0 || bus8.shift_done !== 1'b0 || bus8.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL restart: got gear %0d done %b busy %b required 0 0 0",
                  bus8.gear, bus8.shift_done, bus8.busy);
      end
   endtask

   task automatic test_no_lock;
      go_gear(0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 5000, 0);
         exp_v = sb.pop_front(); got_v = sample(); vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL nolock_sb %0d: got %h required %h", i, got_v, exp_v);
         end
         vectors++;
         if (bus0.gear !== 4'(i + 1) || bus0.busy !== 1'b0 || bus0.shift_done !== 1'b1) begin
            miscompares++;
            $display("FAIL nolock %0d: got gear %0d busy %b done %b required gear %0d busy 0 done 1",
                     i, bus0.gear, bus0.busy, bus0.shift_done, i + 1);
         end
      end
      cyc(0, 0, 0, 0);
      exp_v = sb.pop_front(); got_v = sample(); vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL nolock_idle: got %h required %h", got_v, exp_v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_inputs(0, 0, 0, 0);
      test_reset();
      test_upshift_limit();
      test_lockout();
      test_perfect_window();
      test_simultaneous_down();
      test_async_reset();
      test_reset_status();
      test_no_lock();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
